// File: rtl/rx_payload_store_buf_cp_ctrl.sv
`timescale 1ns/1ps
// rx_payload_store_buf_cp_ctrl
// Moves one RX store-buffer queue entry at a time through these steps:
//   - read the flow's commit pointer;
//   - issue the write-buffer header;
//   - stream temp-buffer beats into the write buffer;
//   - write the commit pointer back;
//   - free the temp-buffer slab.
// Rejected entries only free their slab. Zero-length entries are consumed
// with nothing issued.
// Optional feature: define RX_STORE_BUF_CP_STATS_EN to build the statistics
// counters. Without it the stat outputs are constant zero.
module rx_payload_store_buf_cp_ctrl (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        store_buf_q_req_val,
   output logic        store_buf_q_req_rdy,

   output logic        store_buf_commit_ptr_rd_req_val,
   input  logic        store_buf_commit_ptr_rd_req_rdy,

   input  logic        commit_ptr_store_buf_rd_resp_val,
   output logic        commit_ptr_store_buf_rd_resp_rdy,

   output logic        store_buf_commit_ptr_wr_req_val,
   input  logic        store_buf_commit_ptr_wr_req_rdy,

   output logic        store_buf_tmp_buf_store_rx_rd_req_val,
   input  logic        store_buf_tmp_buf_store_rx_rd_req_rdy,

   input  logic        tmp_buf_store_store_buf_rx_rd_resp_val,
   output logic        tmp_buf_store_store_buf_rx_rd_resp_rdy,

   output logic        store_buf_tmp_buf_free_slab_rx_req_val,
   input  logic        store_buf_tmp_buf_free_slab_rx_req_rdy,

   output logic        ctrl_wr_buf_req_val,
   input  logic        wr_buf_ctrl_req_rdy,

   output logic        ctrl_wr_buf_req_data_val,
   input  logic        wr_buf_ctrl_req_data_rdy,

   output logic        save_q_entry,
   output logic        save_commit_ptr,
   output logic        init_tmp_buf_rd_metadata,
   output logic        update_tmp_buf_rd_metadata,

   input  logic        last_transfer,
   input  logic        accept_payload,
   input  logic        pkt_len_0,

   output logic [31:0] stat_pkts_copied,
   output logic [31:0] stat_pkts_dropped,
   output logic [31:0] stat_beats
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CP_RD_REQ  = 3'd1,
      CP_RD_RESP = 3'd2,
      WR_HDR     = 3'd3,
      TMP_RD     = 3'd4,
      DATA       = 3'd5,
      CP_WR      = 3'd6,
      FREE_SLAB  = 3'd7
   } state_t;

   state_t state_q, state_d;

   logic q_hs;
   logic beat_hs;
   logic cp_wr_hs;

   // The entry handshake uses the reset-gated ready.
   assign q_hs     = store_buf_q_req_val & store_buf_q_req_rdy;
   // In DATA the beat handshake is the temp-buffer response meeting the write-buffer data ready.
   assign beat_hs  = (state_q == DATA) & tmp_buf_store_store_buf_rx_rd_resp_val & wr_buf_ctrl_req_data_rdy;
   assign cp_wr_hs = (state_q == CP_WR) & store_buf_commit_ptr_wr_req_rdy;

   // State register; reset returns to IDLE immediately, even mid-packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state sequencing; each state waits for its own handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (q_hs) begin
               if (pkt_len_0)            state_d = IDLE;
               else if (!accept_payload) state_d = FREE_SLAB;
               else                      state_d = CP_RD_REQ;
            end
         end
         CP_RD_REQ:  if (store_buf_commit_ptr_rd_req_rdy)       state_d = CP_RD_RESP;
         CP_RD_RESP: if (commit_ptr_store_buf_rd_resp_val)      state_d = WR_HDR;
         WR_HDR:     if (wr_buf_ctrl_req_rdy)                   state_d = TMP_RD;
         TMP_RD:     if (store_buf_tmp_buf_store_rx_rd_req_rdy) state_d = DATA;
         DATA:       if (beat_hs) state_d = last_transfer ? CP_WR : TMP_RD;
         CP_WR:      if (store_buf_commit_ptr_wr_req_rdy)       state_d = FREE_SLAB;
         FREE_SLAB:  if (store_buf_tmp_buf_free_slab_rx_req_rdy) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the current state. IDLE ready is gated by
   // rst_n so nothing is accepted while reset is held. DATA passes the beat
   // handshake straight through.
   always_comb begin
      store_buf_q_req_rdy                    = 1'b0;
      store_buf_commit_ptr_rd_req_val        = 1'b0;
      commit_ptr_store_buf_rd_resp_rdy       = 1'b0;
      store_buf_commit_ptr_wr_req_val        = 1'b0;
      store_buf_tmp_buf_store_rx_rd_req_val  = 1'b0;
      tmp_buf_store_store_buf_rx_rd_resp_rdy = 1'b0;
      store_buf_tmp_buf_free_slab_rx_req_val = 1'b0;
      ctrl_wr_buf_req_val                    = 1'b0;
      ctrl_wr_buf_req_data_val               = 1'b0;
      save_q_entry                           = 1'b0;
      save_commit_ptr                        = 1'b0;
      init_tmp_buf_rd_metadata               = 1'b0;
      update_tmp_buf_rd_metadata             = 1'b0;
      case (state_q)
         IDLE: begin
            store_buf_q_req_rdy      = rst_n;
            save_q_entry             = store_buf_q_req_val & rst_n;
            init_tmp_buf_rd_metadata = store_buf_q_req_val & rst_n;
         end
         CP_RD_REQ: store_buf_commit_ptr_rd_req_val = 1'b1;
         CP_RD_RESP: begin
            commit_ptr_store_buf_rd_resp_rdy = 1'b1;
            save_commit_ptr                  = commit_ptr_store_buf_rd_resp_val;
         end
         WR_HDR: ctrl_wr_buf_req_val = 1'b1;
         TMP_RD: store_buf_tmp_buf_store_rx_rd_req_val = 1'b1;
         DATA: begin
            ctrl_wr_buf_req_data_val               = tmp_buf_store_store_buf_rx_rd_resp_val;
            tmp_buf_store_store_buf_rx_rd_resp_rdy = wr_buf_ctrl_req_data_rdy;
            update_tmp_buf_rd_metadata             = beat_hs & ~last_transfer;
         end
         CP_WR:     store_buf_commit_ptr_wr_req_val        = 1'b1;
         FREE_SLAB: store_buf_tmp_buf_free_slab_rx_req_val = 1'b1;
         default: ;
      endcase
   end

`ifdef RX_STORE_BUF_CP_STATS_EN
   logic [31:0] copied_q, dropped_q, beats_q;

   // Statistics counters; they wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         copied_q  <= '0;
         dropped_q <= '0;
         beats_q   <= '0;
      end else begin
         if (cp_wr_hs)                 copied_q  <= copied_q + 32'd1;
         if (q_hs && !accept_payload)  dropped_q <= dropped_q + 32'd1;
         if (beat_hs)                  beats_q   <= beats_q + 32'd1;
      end
   end

   assign stat_pkts_copied  = copied_q;
   assign stat_pkts_dropped = dropped_q;
   assign stat_beats        = beats_q;
`else
   assign stat_pkts_copied  = '0;
   assign stat_pkts_dropped = '0;
   assign stat_beats        = '0;
`endif

endmodule

// File: tb/tb_rx_payload_store_buf_cp_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for rx_payload_store_buf_cp_ctrl. The stimulus pushes the
// expected handshake/pulse sequence of each entry. A negedge monitor pops and
// compares every event the DUT presents.
module tb_rx_payload_store_buf_cp_ctrl;

   localparam int E_ACC = 1, E_CPRD = 2, E_SAVECP = 3, E_HDR = 4, E_TMPRD = 5;
   localparam int E_BEAT = 6, E_UPD = 7, E_CPWR = 8, E_FREE = 9;
   localparam int E_STRAY = 10, E_BADCP = 11, E_BADACC = 12;
   localparam int NOC_DATA_BYTES = 64;
   localparam int BOUND = 300;

   logic clk, rst_n;
   logic store_buf_q_req_val, store_buf_q_req_rdy;
   logic store_buf_commit_ptr_rd_req_val, store_buf_commit_ptr_rd_req_rdy;
   logic commit_ptr_store_buf_rd_resp_val, commit_ptr_store_buf_rd_resp_rdy;
   logic store_buf_commit_ptr_wr_req_val, store_buf_commit_ptr_wr_req_rdy;
   logic store_buf_tmp_buf_store_rx_rd_req_val, store_buf_tmp_buf_store_rx_rd_req_rdy;
   logic tmp_buf_store_store_buf_rx_rd_resp_val, tmp_buf_store_store_buf_rx_rd_resp_rdy;
   logic store_buf_tmp_buf_free_slab_rx_req_val, store_buf_tmp_buf_free_slab_rx_req_rdy;
   logic ctrl_wr_buf_req_val, wr_buf_ctrl_req_rdy;
   logic ctrl_wr_buf_req_data_val, wr_buf_ctrl_req_data_rdy;
   logic save_q_entry, save_commit_ptr, init_tmp_buf_rd_metadata, update_tmp_buf_rd_metadata;
   logic last_transfer, accept_payload, pkt_len_0;
   logic [31:0] stat_pkts_copied, stat_pkts_dropped, stat_beats;

   int n_asserts = 0;
   int n_errs    = 0;
   int exp_q[$];
   int mon_evs[$];
   int nbeats    = 1;
   int beat_cnt  = 0;
   int acc_cnt   = 0;
   int cyc       = 0;
   int free_cyc  = -100;
   int last_gap  = 0;
   int exp_copied = 0, exp_dropped = 0, exp_beats = 0;

   rx_payload_store_buf_cp_ctrl dut (
      .clk                                    (clk),
      .rst_n                                  (rst_n),
      .store_buf_q_req_val                    (store_buf_q_req_val),
      .store_buf_q_req_rdy                    (store_buf_q_req_rdy),
      .store_buf_commit_ptr_rd_req_val        (store_buf_commit_ptr_rd_req_val),
      .store_buf_commit_ptr_rd_req_rdy        (store_buf_commit_ptr_rd_req_rdy),
      .commit_ptr_store_buf_rd_resp_val       (commit_ptr_store_buf_rd_resp_val),
      .commit_ptr_store_buf_rd_resp_rdy       (commit_ptr_store_buf_rd_resp_rdy),
      .store_buf_commit_ptr_wr_req_val        (store_buf_commit_ptr_wr_req_val),
      .store_buf_commit_ptr_wr_req_rdy        (store_buf_commit_ptr_wr_req_rdy),
      .store_buf_tmp_buf_store_rx_rd_req_val  (store_buf_tmp_buf_store_rx_rd_req_val),
      .store_buf_tmp_buf_store_rx_rd_req_rdy  (store_buf_tmp_buf_store_rx_rd_req_rdy),
      .tmp_buf_store_store_buf_rx_rd_resp_val (tmp_buf_store_store_buf_rx_rd_resp_val),
      .tmp_buf_store_store_buf_rx_rd_resp_rdy (tmp_buf_store_store_buf_rx_rd_resp_rdy),
      .store_buf_tmp_buf_free_slab_rx_req_val (store_buf_tmp_buf_free_slab_rx_req_val),
      .store_buf_tmp_buf_free_slab_rx_req_rdy (store_buf_tmp_buf_free_slab_rx_req_rdy),
      .ctrl_wr_buf_req_val                    (ctrl_wr_buf_req_val),
      .wr_buf_ctrl_req_rdy                    (wr_buf_ctrl_req_rdy),
      .ctrl_wr_buf_req_data_val               (ctrl_wr_buf_req_data_val),
      .wr_buf_ctrl_req_data_rdy               (wr_buf_ctrl_req_data_rdy),
      .save_q_entry                           (save_q_entry),
      .save_commit_ptr                        (save_commit_ptr),
      .init_tmp_buf_rd_metadata               (init_tmp_buf_rd_metadata),
      .update_tmp_buf_rd_metadata             (update_tmp_buf_rd_metadata),
      .last_transfer                          (last_transfer),
      .accept_payload                         (accept_payload),
      .pkt_len_0                              (pkt_len_0),
      .stat_pkts_copied                       (stat_pkts_copied),
      .stat_pkts_dropped                      (stat_pkts_dropped),
      .stat_beats                             (stat_beats)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The temp-buffer model flags the final beat of the current entry.
   assign last_transfer = (beat_cnt == nbeats - 1);

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) beat_cnt <= 0;
         else if (store_buf_q_req_val && store_buf_q_req_rdy) beat_cnt <= 0;
         else if (ctrl_wr_buf_req_data_val && wr_buf_ctrl_req_data_rdy) beat_cnt <= beat_cnt + 1;
         cyc <= cyc + 1;
      end
   end

   function automatic string ev_name(input int e);
      case (e)
         E_ACC:    return "ACC";
         E_CPRD:   return "CPRD";
         E_SAVECP: return "SAVECP";
         E_HDR:    return "HDR";
         E_TMPRD:  return "TMPRD";
         E_BEAT:   return "BEAT";
         E_UPD:    return "UPD";
         E_CPWR:   return "CPWR";
         E_FREE:   return "FREE";
         E_STRAY:  return "STRAY_PULSE";
         E_BADCP:  return "CPRESP_NO_SAVE";
         E_BADACC: return "ACC_NO_PULSE";
         default:  return "NONE";
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [12:0] all_outs();
      return {store_buf_q_req_rdy, store_buf_commit_ptr_rd_req_val, commit_ptr_store_buf_rd_resp_rdy,
              store_buf_commit_ptr_wr_req_val, store_buf_tmp_buf_store_rx_rd_req_val,
              tmp_buf_store_store_buf_rx_rd_resp_rdy, store_buf_tmp_buf_free_slab_rx_req_val,
              ctrl_wr_buf_req_val, ctrl_wr_buf_req_data_val, save_q_entry, save_commit_ptr,
              init_tmp_buf_rd_metadata, update_tmp_buf_rd_metadata};
   endfunction

   // Monitor: turn each cycle's handshakes/pulses into ordered events and score them.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            mon_evs.delete();
            if (store_buf_q_req_val && store_buf_q_req_rdy) begin
               mon_evs.push_back((save_q_entry && init_tmp_buf_rd_metadata) ? E_ACC : E_BADACC);
               acc_cnt++;
               last_gap = cyc - free_cyc;
            end else if (save_q_entry || init_tmp_buf_rd_metadata) mon_evs.push_back(E_STRAY);
            if (store_buf_commit_ptr_rd_req_val && store_buf_commit_ptr_rd_req_rdy) mon_evs.push_back(E_CPRD);
            if (commit_ptr_store_buf_rd_resp_val && commit_ptr_store_buf_rd_resp_rdy)
               mon_evs.push_back(save_commit_ptr ? E_SAVECP : E_BADCP);
            else if (save_commit_ptr) mon_evs.push_back(E_STRAY);
            if (ctrl_wr_buf_req_val && wr_buf_ctrl_req_rdy) mon_evs.push_back(E_HDR);
            if (store_buf_tmp_buf_store_rx_rd_req_val && store_buf_tmp_buf_store_rx_rd_req_rdy) mon_evs.push_back(E_TMPRD);
            if (ctrl_wr_buf_req_data_val && wr_buf_ctrl_req_data_rdy) begin
               mon_evs.push_back(E_BEAT);
               if (update_tmp_buf_rd_metadata) mon_evs.push_back(E_UPD);
            end else if (update_tmp_buf_rd_metadata) mon_evs.push_back(E_STRAY);
            if (store_buf_commit_ptr_wr_req_val && store_buf_commit_ptr_wr_req_rdy) mon_evs.push_back(E_CPWR);
            if (store_buf_tmp_buf_free_slab_rx_req_val && store_buf_tmp_buf_free_slab_rx_req_rdy) begin
               mon_evs.push_back(E_FREE);
               free_cyc = cyc;
            end
            foreach (mon_evs[i]) begin
               n_asserts++;
               if (exp_q.size() == 0) begin
                  n_errs++;
                  $display("FAIL event: got %s expected none", ev_name(mon_evs[i]));
               end else begin
                  int e;
                  e = exp_q.pop_front();
                  if (e != mon_evs[i]) begin
                     n_errs++;
                     $display("FAIL event: got %s expected %s", ev_name(mon_evs[i]), ev_name(e));
                  end
               end
            end
         end
      end
   end

   task automatic push_pkt(input int len, input bit acc);
      int nb;
      exp_q.push_back(E_ACC);
      if (!acc) exp_dropped++;
      if (len == 0) return;
      if (!acc) begin
         exp_q.push_back(E_FREE);
         return;
      end
      nb = (len + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
      exp_q.push_back(E_CPRD);
      exp_q.push_back(E_SAVECP);
      exp_q.push_back(E_HDR);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(E_TMPRD);
         exp_q.push_back(E_BEAT);
         if (i < nb - 1) exp_q.push_back(E_UPD);
      end
      exp_q.push_back(E_CPWR);
      exp_q.push_back(E_FREE);
      exp_copied++;
      exp_beats += nb;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (store_buf_q_req_rdy && exp_q.size() == 0) begin
            done = 1;
            break;
         end
      end
      @(posedge clk); #1;
      n_asserts++;
      if (!done) begin
         n_errs++;
         $display("FAIL %s: idle timeout, %0d events outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic set_entry(input int len, input bit acc);
      pkt_len_0      = (len == 0);
      accept_payload = acc;
      nbeats         = (len == 0) ? 1 : (len + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
   endtask

   // Hold the entry valid until n more entries have been accepted.
   task automatic offer(input string name, input int n);
      int start;
      bit done;
      start = acc_cnt;
      done  = 0;
      store_buf_q_req_val = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         @(posedge clk); #1;
         if (acc_cnt >= start + n) begin
            done = 1;
            break;
         end
      end
      store_buf_q_req_val = 1'b0;
      n_asserts++;
      if (!done) begin
         n_errs++;
         $display("FAIL %s: accepted %0d entries expected %0d", name, acc_cnt - start, n);
      end
   endtask

   task automatic send_entry(input string name, input int len, input bit acc);
      wait_idle(name);
      set_entry(len, acc);
      push_pkt(len, acc);
      offer(name, 1);
   endtask

   task automatic chk_stats(input string name);
`ifdef RX_STORE_BUF_CP_STATS_EN
      chk({name, "_copied"},  stat_pkts_copied,  exp_copied);
      chk({name, "_dropped"}, stat_pkts_dropped, exp_dropped);
      chk({name, "_beats"},   stat_beats,        exp_beats);
`else
      chk({name, "_copied"},  stat_pkts_copied,  0);
      chk({name, "_dropped"}, stat_pkts_dropped, 0);
      chk({name, "_beats"},   stat_beats,        0);
`endif
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      store_buf_q_req_val                    = 1'b0;
      store_buf_commit_ptr_rd_req_rdy        = 1'b1;
      commit_ptr_store_buf_rd_resp_val       = 1'b1;
      store_buf_commit_ptr_wr_req_rdy        = 1'b1;
      store_buf_tmp_buf_store_rx_rd_req_rdy  = 1'b1;
      tmp_buf_store_store_buf_rx_rd_resp_val = 1'b1;
      store_buf_tmp_buf_free_slab_rx_req_rdy = 1'b1;
      wr_buf_ctrl_req_rdy                    = 1'b1;
      wr_buf_ctrl_req_data_rdy               = 1'b1;
      accept_payload                         = 1'b1;
      pkt_len_0                              = 1'b0;

      // Reset state
      #12;
      chk("reset_outs", {19'd0, all_outs()}, 32'd0);
      chk("reset_copied",  stat_pkts_copied,  0);
      chk("reset_dropped", stat_pkts_dropped, 0);
      chk("reset_beats",   stat_beats,        0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_rdy", {31'd0, store_buf_q_req_rdy}, 1);

      // Accepted 100-byte entry: two beats, one update pulse
      send_entry("len100", 100, 1'b1);
      wait_idle("len100_done");
      chk_stats("len100");

      // Rejected 40-byte entry: slab free only
      send_entry("reject40", 40, 1'b0);
      wait_idle("reject40_done");
      chk_stats("reject40");

      // Zero-length entry: back in IDLE next cycle, nothing issued
      send_entry("len0", 0, 1'b1);
      @(negedge clk);
      chk("len0_idle", {31'd0, store_buf_q_req_rdy}, 1);
      chk("len0_no_req", {26'd0, store_buf_commit_ptr_rd_req_val, store_buf_commit_ptr_wr_req_val,
                          store_buf_tmp_buf_store_rx_rd_req_val, store_buf_tmp_buf_free_slab_rx_req_val,
                          ctrl_wr_buf_req_val, ctrl_wr_buf_req_data_val}, 0);

      // Back-to-back entries with the entry valid held high
      wait_idle("b2b");
      set_entry(10, 1'b1);
      push_pkt(10, 1'b1);
      push_pkt(10, 1'b1);
      offer("b2b", 2);
      chk("b2b_gap", last_gap, 1);

      // Write-buffer data backpressure for 10 cycles on beat 2 of 3
      wait_idle("stall");
      set_entry(150, 1'b1);
      push_pkt(150, 1'b1);
      offer("stall", 1);
      seen = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(posedge clk); #1;
         if (beat_cnt == 1) begin
            seen = 1;
            break;
         end
      end
      chk("stall_beat1", {31'd0, seen}, 1);
      wr_buf_ctrl_req_data_rdy = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_hold", {30'd0, ctrl_wr_buf_req_data_val, tmp_buf_store_store_buf_rx_rd_resp_rdy}, 2);
      end
      @(posedge clk); #1;
      wr_buf_ctrl_req_data_rdy = 1'b1;
      wait_idle("stall_done");
      chk_stats("stall");

      // Asynchronous reset while in DATA
      wait_idle("rst_data");
      set_entry(300, 1'b1);
      push_pkt(300, 1'b1);
      offer("rst_data", 1);
      seen = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (ctrl_wr_buf_req_data_val) begin
            seen = 1;
            break;
         end
      end
      chk("rst_reach_data", {31'd0, seen}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {19'd0, all_outs()}, 0);
      exp_q.delete();
      exp_copied = 0; exp_dropped = 0; exp_beats = 0;
      store_buf_q_req_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_held_outs", {19'd0, all_outs()}, 0);
      end
      chk_stats("rst_held");
      store_buf_q_req_val = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_idle", {31'd0, store_buf_q_req_rdy}, 1);

      // Three single-beat packets after reset, including exactly 64 bytes and 1 byte
      send_entry("len64", 64, 1'b1);
      send_entry("len1", 1, 1'b1);
      send_entry("len30", 30, 1'b1);
      wait_idle("single_done");
      chk_stats("single3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
